// File: rtl/cellrv32_cpu_regfile_mp_pkg.sv
// Shared types for the CELLRV32 multi-port register file.
// State encoding and index-width helper.
package cellrv32_package;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } rf_state_t;

    function automatic int rf_idx_width(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/cellrv32_cpu_regfile_mp_if.sv
// Control/execute side bundle of the register file.
// master = core side, slave = register file.
interface cellrv32_cpu_regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NUM_RD = 2
);
    logic                     wb_we_i;
    logic [4:0]               wb_addr_i;
    logic [XLEN-1:0]          wb_data_i;
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*5-1:0]      rd_addr_i;
    logic [NUM_RD*XLEN-1:0]   rd_data_o;
    logic [NUM_RD-1:0]        rd_pend_o;
    logic                     sb_set_i;
    logic [4:0]               sb_addr_i;
    logic                     init_busy_o;

    modport master (
        output wb_we_i, wb_addr_i, wb_data_i,
        output rd_en_i, rd_addr_i,
        output sb_set_i, sb_addr_i,
        input  rd_data_o, rd_pend_o, init_busy_o
    );

    modport slave (
        input  wb_we_i, wb_addr_i, wb_data_i,
        input  rd_en_i, rd_addr_i,
        input  sb_set_i, sb_addr_i,
        output rd_data_o, rd_pend_o, init_busy_o
    );

endinterface

// File: rtl/cellrv32_cpu_regfile_mp_sb.sv
// Pending-write scoreboard for long-latency results.
// Pending flags reflect the same-cycle clear but not the same-cycle set.
module cellrv32_cpu_regfile_sb
    import cellrv32_package::*;
#(
    parameter  int NUM_REGS = 32,
    parameter  int NUM_RD   = 2,
    localparam int IW       = rf_idx_width(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 zero_rd,
    input  logic                 set_en,
    input  logic [IW-1:0]        set_idx,
    input  logic                 clr_en,
    input  logic [IW-1:0]        clr_idx,
    input  logic [NUM_RD-1:0]    rd_en,
    input  logic [NUM_RD*IW-1:0] rd_idx,
    output logic [NUM_RD-1:0]    rd_pend
);

    logic [NUM_REGS-1:0] bits_q;
    logic [NUM_REGS-1:0] bits_clr;
    logic [NUM_REGS-1:0] bits_d;

    // clear first, then set, so a new issue supersedes the returning result
    always_comb begin
        bits_clr = bits_q;
        if (clr_en) begin
            bits_clr[clr_idx] = 1'b0;
        end
        bits_d = bits_clr;
        if (set_en) begin
            bits_d[set_idx] = 1'b1;
        end
    end

    // scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    // registered per-port pending flags, held while the port is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    rd_pend[p] <= zero_rd ? 1'b0 : bits_clr[rd_idx[p*IW +: IW]];
                end
            end
        end
    end

endmodule

// File: rtl/cellrv32_cpu_regfile_mp.sv
// CELLRV32 general-purpose register file: N read ports, bypass,
// post-reset clear sequencer and pending-write scoreboard.
module cellrv32_cpu_regfile_mp
    import cellrv32_package::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2,
    parameter bit BYPASS_EN = 1'b1,
    parameter bit CLEAR_EN  = 1'b1
) (
    input logic                      clk_i,
    input logic                      rst_i,
    cellrv32_cpu_regfile_mp_if.slave rf
);

    localparam int IW = rf_idx_width(NUM_REGS);

    rf_state_t              state_q;
    rf_state_t              state_d;
    logic [IW-1:0]          cnt_q;
    logic [IW-1:0]          cnt_d;
    logic                   init_act;
    logic                   run;
    logic                   clr_en;
    logic                   rd_zero;

    logic [XLEN-1:0]        mem [NUM_REGS];
    logic [IW-1:0]          wr_idx;
    logic [IW-1:0]          sb_idx;
    logic [NUM_RD*IW-1:0]   rd_idx;
    logic                   wr_en;
    logic                   set_en;
    logic [XLEN-1:0]        rd_next [NUM_RD];
    logic [NUM_RD*XLEN-1:0] rd_data_q;
    logic                   unused_addr_bits;

    // Only the low index bits select an entry; RV32E aliases bit 4.
    assign wr_idx = rf.wb_addr_i[IW-1:0];
    assign sb_idx = rf.sb_addr_i[IW-1:0];

    for (genvar g = 0; g < NUM_RD; g++) begin : g_idx
        assign rd_idx[g*IW +: IW] = rf.rd_addr_i[g*5 +: IW];
    end

    assign unused_addr_bits = ^{rf.wb_addr_i, rf.sb_addr_i, rf.rd_addr_i};

    // state register and clear counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: walk every entry once, then run until the next reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!CLEAR_EN || cnt_q == IW'(NUM_REGS - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
        endcase
    end

    // FSM outputs: clear enable, run qualifier and stall request
    always_comb begin
        init_act       = (state_q == S_INIT) && CLEAR_EN;
        run            = !rst_i && !init_act;
        clr_en         = !rst_i && init_act;
        rd_zero        = !run;
        rf.init_busy_o = rst_i || init_act;
    end

    assign wr_en  = run && rf.wb_we_i && (wr_idx != '0);
    assign set_en = run && rf.sb_set_i && (sb_idx != '0);

    // single array write port shared by the clear walk and write-back
    always_ff @(posedge clk_i) begin
        if (clr_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= rf.wb_data_i;
        end
    end

    // read mux: x0 and init return zero, matching write may forward
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_next[p] = '0;
            if (run && rd_idx[p*IW +: IW] != '0) begin
                if (BYPASS_EN && wr_en && wr_idx == rd_idx[p*IW +: IW]) begin
                    rd_next[p] = rf.wb_data_i;
                end else begin
                    rd_next[p] = mem[rd_idx[p*IW +: IW]];
                end
            end
        end
    end

    // registered read data, held while a port is idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rf.rd_en_i[p]) begin
                    rd_data_q[p*XLEN +: XLEN] <= rd_next[p];
                end
            end
        end
    end

    assign rf.rd_data_o = rd_data_q;

    cellrv32_cpu_regfile_sb #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) u_sb (
        .clk      (clk_i),
        .rst      (rst_i),
        .zero_rd  (rd_zero),
        .set_en   (set_en),
        .set_idx  (sb_idx),
        .clr_en   (wr_en),
        .clr_idx  (wr_idx),
        .rd_en    (rf.rd_en_i),
        .rd_idx   (rd_idx),
        .rd_pend  (rf.rd_pend_o)
    );

endmodule
